regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Sequences writes into the 3-port register file: shares its single write port
//  (we3/a3/wd3) between pipeline writeback (p0) and a multi-cycle unit (p1).
//  Fixed priority to p0, with an anti-starvation override for p1. Keeps a
//  pending-write scoreboard so decode can stall on operands not yet written.
//  Sits between the writeback stage and RegisterFile.
// PARAMETERS
//  XLEN      32  data width of write port
//  NREG      32  number of architectural registers (address width = $clog2(NREG))
//  MAX_WAIT  4   cycles p1 may be refused before it is forced through (>=1)
// PORTS
//  clk        in   1     clock, all state on rising edge
//  reset      in   1     asynchronous, active-high reset
//  p0_valid   in   1     pipeline writeback request
//  p0_ready   out  1     p0 accepted this cycle when valid&ready
//  p0_rd      in   5     p0 destination register
//  p0_data    in   XLEN  p0 write data
//  p1_valid   in   1     multi-cycle unit writeback request
//  p1_ready   out  1     p1 accepted this cycle when valid&ready
//  p1_rd      in   5     p1 destination register
//  p1_data    in   XLEN  p1 write data
//  iss_valid  in   1     multi-cycle op issued this cycle
//  iss_rd     in   5     its destination (marked busy)
//  rs1, rs2   in   5     decode source registers
//  rs1_busy   out  1     rs1 has a write not yet visible in the file
//  rs2_busy   out  1     same for rs2
//  we3        out  1     registered write enable to RegisterFile
//  a3         out  5     registered write address
//  wd3        out  XLEN  registered write data
// BEHAVIOUR
//  Reset (async, any time): busy[] all 0, wait_cnt=0, we3=0, a3=0, wd3=0;
//   staged write discarded, no write reaches the file in the following cycle.
//  Arbitration (combinational ready, one grant per cycle max):
//   force1   = p1_valid && wait_cnt==MAX_WAIT
//   p0_ready = !force1 ;  p1_ready = force1 || !p0_valid
//  wait_cnt: +1 (saturating at MAX_WAIT) when p1_valid && !p1_ready;
//   cleared to 0 on p1 transfer or when p1_valid=0.
//  Requesters hold valid/rd/data stable until transfer; arbiter does not check.
//  Write stage, latency 1: transfer in cycle N -> cycle N+1 we3=1, a3=rd,
//   wd3=data; RegisterFile commits at end of N+1. No transfer -> we3=0,a3=0,wd3=0.
//  rd==0 transfer: accepted (ready handshake completes) but dropped: we3=0,
//   a3=0, wd3=0 next cycle; never drive a write to x0.
//  Scoreboard busy[NREG]: set on iss_valid && iss_rd!=0; cleared on p1 transfer
//   with that rd. Same-cycle set and clear of one reg -> set wins (stays 1).
//   Issue to an already-busy reg leaves it 1 (single bit, no count).
//   p0 transfers never touch busy[]. p1 to a non-busy rd still writes.
//  rsX_busy = (rsX!=0) && (busy[rsX] || (we3 && a3==rsX)); covers the in-flight
//   cycle, so rsX_busy falls the cycle after we3 for that reg.
//  x0 is never busy; rs==0 always reports 0.
// TESTING
//  1 p0 valid rd=5 data=32'hDEADBEEF, p1 idle -> p0_ready=1; next cycle we3=1,
//    a3=5, wd3=DEADBEEF; following cycle we3=0.
//  2 p0 and p1 valid continuously, MAX_WAIT=4 -> p0 granted cycles 0-3, cycle 4
//    p0_ready=0/p1_ready=1, wait_cnt back to 0, p0 resumes cycle 5.
//  3 iss_valid rd=7; rs1=7 -> rs1_busy=1 from next cycle; p1 transfer rd=7 at N
//    -> busy[7]=0 at N+1 but rs1_busy=1 (we3,a3=7); rs1_busy=0 at N+2.
//  4 p0 rd=0 data=32'h1234 -> handshake completes, we3 stays 0, a3=0, wd3=0.
//  5 iss_valid rd=3 same cycle as p1 transfer rd=3 -> busy[3] remains 1.
//  6 busy[9]=1 and p0 transfer rd=2 in flight, assert reset mid-cycle -> we3,
//    a3, wd3, rs1_busy(rs1=9) drop to 0 immediately; no write after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 3-port register file: p0 (writeback) has priority,
// p1 (multi-cycle unit) is forced through after MAX_WAIT refusals; tracks pending p1 writes.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    p0_valid,
    output logic                    p0_ready,
    input  logic [$clog2(NREG)-1:0] p0_rd,
    input  logic [XLEN-1:0]         p0_data,
    input  logic                    p1_valid,
    output logic                    p1_ready,
    input  logic [$clog2(NREG)-1:0] p1_rd,
    input  logic [XLEN-1:0]         p1_data,
    input  logic                    iss_valid,
    input  logic [$clog2(NREG)-1:0] iss_rd,
    input  logic [$clog2(NREG)-1:0] rs1,
    input  logic [$clog2(NREG)-1:0] rs2,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic                    we3,
    output logic [$clog2(NREG)-1:0] a3,
    output logic [XLEN-1:0]         wd3
);

    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0]   wait_cnt;
    logic [CW-1:0]   wait_cnt_nxt;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            force1;
    logic            p0_xfer;
    logic            p1_xfer;
    logic            wr_en_nxt;
    logic [AW-1:0]   wr_addr_nxt;
    logic [XLEN-1:0] wr_data_nxt;

    // Grant logic: at most one of p0/p1 can transfer in a cycle.
    always_comb begin
        force1   = p1_valid && (wait_cnt == CW'(MAX_WAIT));
        p0_ready = !force1;
        p1_ready = force1 || !p0_valid;
        p0_xfer  = p0_valid && p0_ready;
        p1_xfer  = p1_valid && p1_ready;
    end

    // Starvation counter: counts consecutive refusals of a waiting p1.
    always_comb begin
        wait_cnt_nxt = '0;
        if (p1_valid && !p1_ready) begin
            wait_cnt_nxt = (wait_cnt == CW'(MAX_WAIT)) ? wait_cnt : wait_cnt + CW'(1);
        end
    end

    // Staged write; transfers to x0 complete the handshake but are dropped.
    always_comb begin
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = '0;
        wr_data_nxt = '0;
        if (p0_xfer && (p0_rd != '0)) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = p0_rd;
            wr_data_nxt = p0_data;
        end else if (p1_xfer && (p1_rd != '0)) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = p1_rd;
            wr_data_nxt = p1_data;
        end
    end

    // Scoreboard update; a same-cycle issue wins over a p1 completion.
    always_comb begin
        busy_nxt = busy;
        if (p1_xfer) begin
            busy_nxt[p1_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // The in-flight write term keeps the operand busy until the file has committed it.
    always_comb begin
        rs1_busy = (rs1 != '0) && (busy[rs1] || (we3 && (a3 == rs1)));
        rs2_busy = (rs2 != '0) && (busy[rs2] || (we3 && (a3 == rs2)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            busy     <= '0;
            we3      <= 1'b0;
            a3       <= '0;
            wd3      <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            busy     <= busy_nxt;
            we3      <= wr_en_nxt;
            a3       <= wr_addr_nxt;
            wd3      <= wr_data_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a cycle-level reference model checked every
// negedge, plus hand-computed literal checks for each scenario.
module tb_regfile_wb_arbiter;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NREG     = 32;
    localparam int unsigned MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_valid = 1'b0;
    logic        p0_ready;
    logic [4:0]  p0_rd = '0;
    logic [31:0] p0_data = '0;
    logic        p1_valid = 1'b0;
    logic        p1_ready;
    logic [4:0]  p1_rd = '0;
    logic [31:0] p1_data = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;

    int tests = 0;
    int fails = 0;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_rd(p0_rd), .p0_data(p0_data),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_rd(p1_rd), .p1_data(p1_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .we3(we3), .a3(a3), .wd3(wd3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: refusal count, pending-register set, and the write due next cycle.
    int          m_wait;
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_a;
    logic [31:0] m_wd;
    logic        m_r0, m_r1, m_x0, m_x1;
    logic        m_we_n;
    logic [4:0]  m_a_n;
    logic [31:0] m_wd_n;
    logic [31:0] m_busy_n;
    int          m_wait_n;

    always_comb begin
        m_r1     = (p1_valid && (m_wait >= int'(MAX_WAIT))) || !p0_valid;
        m_r0     = !(p1_valid && (m_wait >= int'(MAX_WAIT)));
        m_x0     = p0_valid && m_r0;
        m_x1     = p1_valid && m_r1;
        m_we_n   = 1'b0;
        m_a_n    = '0;
        m_wd_n   = '0;
        if (m_x0 && p0_rd != 5'd0) begin
            m_we_n = 1'b1; m_a_n = p0_rd; m_wd_n = p0_data;
        end else if (m_x1 && p1_rd != 5'd0) begin
            m_we_n = 1'b1; m_a_n = p1_rd; m_wd_n = p1_data;
        end
        m_busy_n = m_busy;
        if (m_x1) m_busy_n[p1_rd] = 1'b0;
        if (iss_valid && iss_rd != 5'd0) m_busy_n[iss_rd] = 1'b1;
        if (p1_valid && !m_r1) m_wait_n = (m_wait + 1 > int'(MAX_WAIT)) ? int'(MAX_WAIT) : m_wait + 1;
        else m_wait_n = 0;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_wait <= 0; m_busy <= '0; m_we <= 1'b0; m_a <= '0; m_wd <= '0;
        end else begin
            m_wait <= m_wait_n; m_busy <= m_busy_n; m_we <= m_we_n; m_a <= m_a_n; m_wd <= m_wd_n;
        end
    end

    function automatic logic exp_busy(input logic [4:0] rs);
        return (rs != 5'd0) && (m_busy[rs] || (m_we && m_a == rs));
    endfunction

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        chk("m.p0_ready", 64'(p0_ready), 64'(m_r0));
        chk("m.p1_ready", 64'(p1_ready), 64'(m_r1));
        chk("m.we3", 64'(we3), 64'(m_we));
        chk("m.a3", 64'(a3), 64'(m_a));
        chk("m.wd3", 64'(wd3), 64'(m_wd));
        chk("m.rs1_busy", 64'(rs1_busy), 64'(exp_busy(rs1)));
        chk("m.rs2_busy", 64'(rs2_busy), 64'(exp_busy(rs2)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_valid = 1'b0; p1_valid = 1'b0; iss_valid = 1'b0;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        chk("rst.we3", 64'(we3), 64'(0));
        chk("rst.a3", 64'(a3), 64'(0));
        chk("rst.wd3", 64'(wd3), 64'(0));
        tick();

        // 1: single p0 write
        p0_valid = 1'b1; p0_rd = 5'd5; p0_data = 32'hDEADBEEF;
        #2 chk("t1.p0_ready", 64'(p0_ready), 64'(1));
        tick(); idle();
        chk("t1.we3", 64'(we3), 64'(1));
        chk("t1.a3", 64'(a3), 64'(5));
        chk("t1.wd3", 64'(wd3), 64'hDEADBEEF);
        tick();
        chk("t1.we3_off", 64'(we3), 64'(0));

        // 2: both requesting continuously; p1 forced on the fifth cycle
        p0_valid = 1'b1; p0_rd = 5'd1; p0_data = 32'h11111111;
        p1_valid = 1'b1; p1_rd = 5'd2; p1_data = 32'h22222222;
        for (int c = 0; c < 6; c++) begin
            #2;
            chk("t2.p0_ready", 64'(p0_ready), 64'(c != 4));
            chk("t2.p1_ready", 64'(p1_ready), 64'(c == 4));
            tick();
            chk("t2.a3", 64'(a3), (c == 4) ? 64'(2) : 64'(1));
            if (c == 4) p1_valid = 1'b0;
        end
        idle(); tick();

        // 3: issue marks busy; p1 completion keeps it busy through the in-flight cycle
        iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
        tick(); idle();
        chk("t3.busy_after_iss", 64'(rs1_busy), 64'(1));
        tick(); tick();
        chk("t3.busy_held", 64'(rs1_busy), 64'(1));
        p1_valid = 1'b1; p1_rd = 5'd7; p1_data = 32'hCAFE0007;
        #2 chk("t3.p1_ready", 64'(p1_ready), 64'(1));
        tick(); idle();
        chk("t3.inflight_busy", 64'(rs1_busy), 64'(1));
        chk("t3.we3", 64'(we3), 64'(1));
        chk("t3.a3", 64'(a3), 64'(7));
        tick();
        chk("t3.busy_clear", 64'(rs1_busy), 64'(0));

        // 4: x0 write dropped, x0 never busy
        p0_valid = 1'b1; p0_rd = 5'd0; p0_data = 32'h1234;
        iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
        #2 chk("t4.p0_ready", 64'(p0_ready), 64'(1));
        tick(); idle();
        chk("t4.we3", 64'(we3), 64'(0));
        chk("t4.a3", 64'(a3), 64'(0));
        chk("t4.wd3", 64'(wd3), 64'(0));
        chk("t4.rs0", 64'(rs1_busy), 64'(0));
        tick();

        // 5: same-cycle issue and completion on r3 -> stays busy
        iss_valid = 1'b1; iss_rd = 5'd3; rs2 = 5'd3;
        tick();
        p1_valid = 1'b1; p1_rd = 5'd3; p1_data = 32'h33;
        tick(); idle();
        tick();
        chk("t5.set_wins", 64'(rs2_busy), 64'(1));
        p1_valid = 1'b1; p1_rd = 5'd3; p1_data = 32'h34;
        tick(); idle();
        chk("t5.inflight", 64'(rs2_busy), 64'(1));
        tick();
        chk("t5.cleared", 64'(rs2_busy), 64'(0));

        // 6: asynchronous reset with a write in flight and one staged
        iss_valid = 1'b1; iss_rd = 5'd9; rs1 = 5'd9;
        p0_valid = 1'b1; p0_rd = 5'd2; p0_data = 32'h0000BEEF;
        tick(); iss_valid = 1'b0;
        chk("t6.pre_we3", 64'(we3), 64'(1));
        chk("t6.pre_busy", 64'(rs1_busy), 64'(1));
        #2 reset = 1'b1;
        #1;
        chk("t6.rst_we3", 64'(we3), 64'(0));
        chk("t6.rst_a3", 64'(a3), 64'(0));
        chk("t6.rst_wd3", 64'(wd3), 64'(0));
        chk("t6.rst_busy", 64'(rs1_busy), 64'(0));
        tick();
        idle(); reset = 1'b0;
        chk("t6.post_we3", 64'(we3), 64'(0));
        tick();
        chk("t6.post2_we3", 64'(we3), 64'(0));
        chk("t6.post_busy", 64'(rs1_busy), 64'(0));
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
